// File: rtl/ball_motion_if.sv
// Signal bundle between the Breakout game logic and the ball engine.
// The game side (master) drives serve, paddle and collision inputs; the ball engine (slave) drives the ball state.
interface ball_motion_if;
    logic       start;
    logic [9:0] paddle_x;
    logic       topbotcol;
    logic       LRcol;
    logic [9:0] ballx;
    logic [9:0] bally;
    logic       dir_x;
    logic       dir_y;
    logic       ball_lost;
    logic [1:0] lives;
    logic       game_over;

    modport master (
        output start,
        output paddle_x,
        output topbotcol,
        output LRcol,
        input  ballx,
        input  bally,
        input  dir_x,
        input  dir_y,
        input  ball_lost,
        input  lives,
        input  game_over
    );

    modport slave (
        input  start,
        input  paddle_x,
        input  topbotcol,
        input  LRcol,
        output ballx,
        output bally,
        output dir_x,
        output dir_y,
        output ball_lost,
        output lives,
        output game_over
    );
endinterface

// File: rtl/ball_motion.sv
// Breakout ball engine: holds the ball on the paddle until serve, then steps it one pixel per axis per move tick,
// bouncing off walls, paddle and blocks, and tracks lost balls and remaining lives.
module ball_motion #(
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int PADDLE_Y   = 440,
    parameter int PADDLE_W   = 64,
    parameter int TICK_DIV   = 250000,
    parameter int LIVES_INIT = 3
) (
    input  logic         clk,
    input  logic         rst,
    ball_motion_if.slave bus
);

    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [CNT_W-1:0] TICK_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [9:0]       X_MAX       = 10'(SCREEN_W - 1);
    localparam logic [9:0]       Y_MAX       = 10'(SCREEN_H - 1);
    localparam logic [9:0]       Y_SERVE     = 10'(PADDLE_Y - 1);
    localparam logic [9:0]       PADDLE_HALF = 10'(PADDLE_W / 2);
    localparam logic [10:0]      PADDLE_SPAN = 11'(PADDLE_W - 1);
    localparam logic [1:0]       LIVES_START = 2'(LIVES_INIT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MOVE = 2'd1;
    localparam logic [1:0] ST_LOST = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    logic [1:0]       state_reg;
    logic [9:0]       ballx_reg;
    logic [9:0]       bally_reg;
    logic             dir_x_reg;
    logic             dir_y_reg;
    logic [1:0]       lives_reg;
    logic [CNT_W-1:0] tick_cnt_reg;
    logic             tb_pend_reg;
    logic             lr_pend_reg;

    logic             tick;
    logic             tb_seen;
    logic             lr_seen;
    logic             leaving_bottom;
    logic             paddle_hit;
    logic [10:0]      paddle_right;
    logic [9:0]       serve_x;
    logic             dir_x_next;
    logic             dir_y_next;
    logic [9:0]       ballx_next;
    logic [9:0]       bally_next;

    assign tick         = (state_reg == ST_MOVE) && (tick_cnt_reg == TICK_LAST);
    // A collision pulse on the tick cycle itself must count towards that tick.
    assign tb_seen      = tb_pend_reg | bus.topbotcol;
    assign lr_seen      = lr_pend_reg | bus.LRcol;
    assign serve_x      = bus.paddle_x + PADDLE_HALF;
    assign paddle_right = {1'b0, bus.paddle_x} + PADDLE_SPAN;

    assign leaving_bottom = (bally_reg == Y_MAX) && dir_y_reg;
    assign paddle_hit     = (bally_reg == Y_SERVE) && dir_y_reg
                          && (ballx_reg >= bus.paddle_x)
                          && ({1'b0, ballx_reg} <= paddle_right);

    // Wall and paddle rules win over block flags so each axis reverses at most once per tick.
    always_comb begin
        dir_x_next = dir_x_reg;
        if ((ballx_reg == 10'd0) && !dir_x_reg) begin
            dir_x_next = 1'b1;
        end else if ((ballx_reg == X_MAX) && dir_x_reg) begin
            dir_x_next = 1'b0;
        end else if (lr_seen) begin
            dir_x_next = ~dir_x_reg;
        end
    end

    always_comb begin
        dir_y_next = dir_y_reg;
        if (paddle_hit) begin
            dir_y_next = 1'b0;
        end else if ((bally_reg == 10'd0) && !dir_y_reg) begin
            dir_y_next = 1'b1;
        end else if (tb_seen) begin
            dir_y_next = ~dir_y_reg;
        end
    end

    // The step uses the freshly resolved direction, so a bounce and its first step share one edge.
    always_comb begin
        ballx_next = dir_x_next ? (ballx_reg + 10'd1) : (ballx_reg - 10'd1);
        bally_next = dir_y_next ? (bally_reg + 10'd1) : (bally_reg - 10'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            ballx_reg    <= serve_x;
            bally_reg    <= Y_SERVE;
            dir_x_reg    <= 1'b1;
            dir_y_reg    <= 1'b0;
            lives_reg    <= LIVES_START;
            tick_cnt_reg <= '0;
            tb_pend_reg  <= 1'b0;
            lr_pend_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    ballx_reg    <= serve_x;
                    bally_reg    <= Y_SERVE;
                    tick_cnt_reg <= '0;
                    tb_pend_reg  <= 1'b0;
                    lr_pend_reg  <= 1'b0;
                    if (bus.start) begin
                        state_reg <= ST_MOVE;
                        dir_x_reg <= 1'b1;
                        dir_y_reg <= 1'b0;
                    end
                end

                ST_MOVE: begin
                    if (tick) begin
                        tick_cnt_reg <= '0;
                        tb_pend_reg  <= 1'b0;
                        lr_pend_reg  <= 1'b0;
                        if (leaving_bottom) begin
                            state_reg <= ST_LOST;
                        end else begin
                            dir_x_reg <= dir_x_next;
                            dir_y_reg <= dir_y_next;
                            ballx_reg <= ballx_next;
                            bally_reg <= bally_next;
                        end
                    end else begin
                        tick_cnt_reg <= tick_cnt_reg + CNT_W'(1);
                        tb_pend_reg  <= tb_seen;
                        lr_pend_reg  <= lr_seen;
                    end
                end

                ST_LOST: begin
                    // Position stays frozen for the lost cycle and is re-parked on the way out.
                    lives_reg <= lives_reg - 2'd1;
                    ballx_reg <= serve_x;
                    bally_reg <= Y_SERVE;
                    state_reg <= (lives_reg == 2'd1) ? ST_OVER : ST_IDLE;
                end

                default: begin
                    ballx_reg    <= serve_x;
                    bally_reg    <= Y_SERVE;
                    tick_cnt_reg <= '0;
                    tb_pend_reg  <= 1'b0;
                    lr_pend_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ballx     = ballx_reg;
    assign bus.bally     = bally_reg;
    assign bus.dir_x     = dir_x_reg;
    assign bus.dir_y     = dir_y_reg;
    assign bus.ball_lost = (state_reg == ST_LOST);
    assign bus.lives     = lives_reg;
    assign bus.game_over = (state_reg == ST_OVER);

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: two instances (three lives and one life) with a fast move tick,
// expectations queued as stimulus is applied and checked at the following falling edge.
module tb_ball_motion;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;

    always #5 clk = ~clk;

    ball_motion_if ifa ();
    ball_motion_if ifb ();

    ball_motion #(.TICK_DIV(4), .LIVES_INIT(3)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ifa)
    );

    ball_motion #(.TICK_DIV(4), .LIVES_INIT(1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ifb)
    );

    typedef struct {
        string tag;
        int    dut;
        int    sel;
        int    val;
    } exp_t;

    exp_t sb[$];
    int vectors     = 0;
    int miscompares = 0;

    function automatic int observe(int d, int sel);
        if (d == 0) begin
            case (sel)
                0:       return int'(ifa.ballx);
                1:       return int'(ifa.bally);
                2:       return int'(ifa.dir_x);
                3:       return int'(ifa.dir_y);
                4:       return int'(ifa.ball_lost);
                5:       return int'(ifa.lives);
                6:       return int'(ifa.game_over);
                default: return -1;
            endcase
        end else begin
            case (sel)
                0:       return int'(ifb.ballx);
                1:       return int'(ifb.bally);
                2:       return int'(ifb.dir_x);
                3:       return int'(ifb.dir_y);
                4:       return int'(ifb.ball_lost);
                5:       return int'(ifb.lives);
                6:       return int'(ifb.game_over);
                default: return -1;
            endcase
        end
    endfunction

    function automatic string sel_name(int sel);
        case (sel)
            0:       return "ballx";
            1:       return "bally";
            2:       return "dir_x";
            3:       return "dir_y";
            4:       return "ball_lost";
            5:       return "lives";
            6:       return "game_over";
            default: return "unknown";
        endcase
    endfunction

    task automatic push(input string tag, input int d, input int sel, input int val);
        exp_t e;
        e.tag = tag;
        e.dut = d;
        e.sel = sel;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic exp_ball(input string tag, input int d, input int x, input int y, input int dx, input int dy);
        push(tag, d, 0, x);
        push(tag, d, 1, y);
        push(tag, d, 2, dx);
        push(tag, d, 3, dy);
    endtask

    task automatic exp_life(input string tag, input int d, input int lost, input int lv, input int go);
        push(tag, d, 4, lost);
        push(tag, d, 5, lv);
        push(tag, d, 6, go);
    endtask

    task automatic drain();
        exp_t e;
        int   obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.dut, e.sel);
            vectors++;
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s dut%0d %s observed=%0d expected=%0d", e.tag, e.dut, sel_name(e.sel), obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drv(input int d, input bit tbp, input bit lrp);
        if (d == 0) begin
            ifa.topbotcol = tbp;
            ifa.LRcol     = lrp;
        end else begin
            ifb.topbotcol = tbp;
            ifb.LRcol     = lrp;
        end
    endtask

    // Advances exactly one move tick from a tick-aligned point, optionally pulsing collisions
    // either mid-interval or on the tick cycle itself.
    task automatic tick_with(input int d, input bit tbp, input bit lrp, input bit on_tick);
        if (!on_tick) begin
            step(1);
            drv(d, tbp, lrp);
            step(1);
            drv(d, 1'b0, 1'b0);
            step(2);
        end else begin
            step(3);
            drv(d, tbp, lrp);
            step(1);
            drv(d, 1'b0, 1'b0);
        end
    endtask

    task automatic ticks(input int n);
        step(4 * n);
    endtask

    task automatic wait_lost(input int d, input int budget, input string tag);
        int n;
        n = 0;
        while (observe(d, 4) != 1 && n < budget) begin
            step(1);
            n++;
        end
        vectors++;
        assert (observe(d, 4) == 1) else begin
            miscompares++;
            $error("FAIL %s timeout observed_ball_lost=%0d expected=1 after %0d cycles", tag, observe(d, 4), n);
        end
    endtask

    initial begin
        rst_a         = 1'b1;
        rst_b         = 1'b1;
        ifa.start     = 1'b0;
        ifa.paddle_x  = 10'd100;
        ifa.topbotcol = 1'b0;
        ifa.LRcol     = 1'b0;
        ifb.start     = 1'b0;
        ifb.paddle_x  = 10'd100;
        ifb.topbotcol = 1'b0;
        ifb.LRcol     = 1'b0;

        // ---------------- three-life instance ----------------
        exp_ball("reset", 0, 132, 439, 1, 0);
        exp_life("reset", 0, 0, 3, 0);
        step(2);
        drain();
        rst_a = 1'b0;

        ifa.paddle_x = 10'd200;
        exp_ball("idle_track", 0, 232, 439, 1, 0);
        step(1);
        drain();
        ifa.paddle_x = 10'd100;
        exp_ball("idle_back", 0, 132, 439, 1, 0);
        step(1);
        drain();

        ifa.start = 1'b1;
        step(1);
        ifa.start    = 1'b0;
        ifa.paddle_x = 10'd300;
        exp_ball("pre_tick", 0, 132, 439, 1, 0);
        step(3);
        drain();
        exp_ball("first_move", 0, 133, 438, 1, 0);
        step(1);
        drain();

        exp_ball("tb_mid", 0, 134, 439, 1, 1);
        tick_with(0, 1'b1, 1'b0, 1'b0);
        drain();
        exp_ball("tb_on_tick", 0, 135, 438, 1, 0);
        tick_with(0, 1'b1, 1'b0, 1'b1);
        drain();
        exp_ball("tb_cleared", 0, 136, 437, 1, 0);
        tick_with(0, 1'b0, 1'b0, 1'b0);
        drain();
        exp_ball("lr_mid", 0, 135, 436, 0, 0);
        tick_with(0, 1'b0, 1'b1, 1'b0);
        drain();
        exp_ball("lr_cleared", 0, 134, 435, 0, 0);
        tick_with(0, 1'b0, 1'b0, 1'b0);
        drain();
        exp_ball("lr_on_tick", 0, 135, 434, 1, 0);
        tick_with(0, 1'b0, 1'b1, 1'b1);
        drain();

        ticks(433);
        exp_ball("top_row", 0, 569, 0, 1, 0);
        tick_with(0, 1'b0, 1'b0, 1'b0);
        drain();
        exp_ball("top_wall_and_block", 0, 570, 1, 1, 1);
        tick_with(0, 1'b1, 1'b0, 1'b0);
        drain();

        ticks(68);
        exp_ball("right_col", 0, 639, 70, 1, 1);
        tick_with(0, 1'b0, 1'b0, 1'b0);
        drain();
        exp_ball("corner_single_flip", 0, 638, 71, 0, 1);
        tick_with(0, 1'b0, 1'b1, 1'b1);
        drain();
        exp_ball("after_corner", 0, 637, 72, 0, 1);
        tick_with(0, 1'b0, 1'b0, 1'b0);
        drain();

        ifa.paddle_x = 10'd207;
        ticks(366);
        exp_ball("paddle_row", 0, 270, 439, 0, 1);
        tick_with(0, 1'b0, 1'b0, 1'b0);
        drain();
        exp_ball("paddle_edge_hit", 0, 269, 438, 0, 0);
        tick_with(0, 1'b0, 1'b0, 1'b0);
        drain();

        ifa.paddle_x = 10'd204;
        exp_ball("block_down", 0, 268, 439, 0, 1);
        tick_with(0, 1'b1, 1'b0, 1'b0);
        drain();
        exp_ball("paddle_miss", 0, 267, 440, 0, 1);
        tick_with(0, 1'b0, 1'b0, 1'b0);
        drain();

        ticks(38);
        exp_ball("bottom_row", 0, 228, 479, 0, 1);
        tick_with(0, 1'b0, 1'b0, 1'b0);
        drain();
        push("lost_frozen", 0, 0, 228);
        push("lost_frozen", 0, 1, 479);
        exp_life("lost_pulse", 0, 1, 3, 0);
        step(4);
        drain();
        push("back_idle", 0, 0, 236);
        push("back_idle", 0, 1, 439);
        exp_life("back_idle", 0, 0, 2, 0);
        step(1);
        drain();

        // ---------------- one-life instance ----------------
        exp_life("b_reset", 1, 0, 1, 0);
        step(1);
        drain();
        rst_b = 1'b0;
        ifb.start = 1'b1;
        step(1);
        ifb.start = 1'b0;
        exp_ball("b_serve_flip", 1, 133, 440, 1, 1);
        tick_with(1, 1'b1, 1'b0, 1'b0);
        drain();

        wait_lost(1, 400, "b_wait_lost");
        push("b_lost_frozen", 1, 0, 172);
        push("b_lost_frozen", 1, 1, 479);
        exp_life("b_lost", 1, 1, 1, 0);
        drain();

        ifb.paddle_x = 10'd50;
        exp_life("b_over", 1, 0, 0, 1);
        push("b_over_park", 1, 0, 82);
        push("b_over_park", 1, 1, 439);
        step(1);
        drain();

        ifb.start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push("b_start_ignored", 1, 6, 1);
            push("b_start_ignored", 1, 0, 82);
            step(1);
            drain();
        end
        ifb.start = 1'b0;

        rst_b = 1'b1;
        exp_life("b_rst_from_over", 1, 0, 1, 0);
        step(1);
        drain();
        rst_b = 1'b0;

        // Reset in flight with a latched block flag: the flag must not survive into the next serve.
        ifb.start = 1'b1;
        step(1);
        ifb.start = 1'b0;
        step(1);
        ifb.topbotcol = 1'b1;
        step(1);
        ifb.topbotcol = 1'b0;
        rst_b = 1'b1;
        exp_ball("b_midflight_rst", 1, 82, 439, 1, 0);
        exp_life("b_midflight_rst", 1, 0, 1, 0);
        step(1);
        drain();
        rst_b = 1'b0;
        ifb.start = 1'b1;
        step(1);
        ifb.start = 1'b0;
        exp_ball("b_no_stale_pend", 1, 83, 438, 1, 0);
        step(4);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Consumes the per-block collision pulses (hit flags, top/bottom and left/right collision) and owns the ball for the Breakout game.
- Holds the ball on the paddle until serve, then steps the ball 1 pixel per axis per move tick.
- Reflects the ball off blocks, walls and the paddle, and detects a lost ball.
- Drives ballx/bally back to every block collision detector and to the VGA renderer.

Parameters:
- SCREEN_W, 640, horizontal pixel count; ballx range 0..SCREEN_W-1
- SCREEN_H, 480, vertical pixel count; bally range 0..SCREEN_H-1
- PADDLE_Y, 440, paddle top row
- PADDLE_W, 64, paddle width in pixels
- TICK_DIV, 250000, clk cycles per move tick (min 2)
- LIVES_INIT, 3, balls per game (1..3)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  serve request, level or pulse, sampled in IDLE
- paddle_x  in  10  paddle left edge
- topbotcol  in  1  OR of all blocks' top/bottom collision pulses
- LRcol  in  1  OR of all blocks' left/right collision pulses
- ballx  out  10  ball x position
- bally  out  10  ball y position
- dir_x  out  1  1 = moving right (+x), 0 = left
- dir_y  out  1  1 = moving down (+y), 0 = up
- ball_lost  out  1  one-cycle pulse when the ball leaves the bottom
- lives  out  2  remaining balls
- game_over  out  1  high once lives reach 0; held until rst

Behaviour:
- All state is synchronous to clk. rst is sampled on the clk edge and overrides everything.
- Reset values:
  - state = IDLE
  - ballx = paddle_x + PADDLE_W/2, bally = PADDLE_Y-1
  - dir_x = 1, dir_y = 0
  - ball_lost = 0, lives = LIVES_INIT, game_over = 0
  - tick counter = 0, pending flags = 0
- States: IDLE, MOVE, LOST, OVER.
- IDLE:
  - Every cycle: ballx = paddle_x + PADDLE_W/2, bally = PADDLE_Y-1.
  - Pending flags and tick counter held at 0.
  - start=1 -> MOVE next cycle with dir_x=1, dir_y=0.
- MOVE:
  - Tick counter counts 0..TICK_DIV-1 and wraps. A move tick occurs on the cycle the count equals TICK_DIV-1, so the first tick comes TICK_DIV cycles after entering MOVE.
  - topbotcol=1 sets tb_pend; LRcol=1 sets lr_pend. Pulses are latched, never lost between ticks.
  - A pulse arriving on the tick cycle itself is included in that tick.
  - On a tick, the ball is lost if bally == SCREEN_H-1 and dir_y=1: go to LOST, position frozen. Otherwise:
    - x rule: ballx==0 and dir_x=0 -> dir_x=1; else ballx==SCREEN_W-1 and dir_x=1 -> dir_x=0; else lr_pend -> dir_x inverted.
    - y rule: paddle hit (bally==PADDLE_Y-1, dir_y=1, paddle_x <= ballx <= paddle_x+PADDLE_W-1) -> dir_y=0; else bally==0 and dir_y=0 -> dir_y=1; else tb_pend -> dir_y inverted.
    - Wall and paddle rules take priority over pending flags, so each axis flips at most once per tick.
    - ballx/bally then step 1 pixel in the NEW direction on the same edge.
    - tb_pend and lr_pend clear on every tick.
- LOST (1 cycle):
  - ball_lost=1, lives decremented.
  - If the new lives value is 0 -> OVER, else -> IDLE.
- OVER:
  - game_over=1, ball parked at IDLE position, start ignored.
  - Only rst leaves OVER.
- Arithmetic: 10-bit unsigned. Boundary checks happen before the step, so position never wraps below 0 or beyond SCREEN_W-1 / SCREEN_H-1.
- Reset mid-flight returns to IDLE with full lives on the next edge. Pending flags are discarded.

Test Plan:
- Serve: TICK_DIV=4, paddle_x=100, rst, start pulse -> ballx=132, bally=439 in IDLE; first move 4 cycles after MOVE entry gives ballx=133, bally=438, dir_x=1, dir_y=0.
- Block top/bottom: topbotcol pulse mid-interval -> on next tick dir_y flips 0->1 and bally increments; pulse on the exact tick cycle gives the same result; tb_pend clears after the tick.
- Corner: ball at ballx=639 with dir_x=1 and lr_pend set in the same tick -> dir_x=0 exactly once (no double flip), ballx=638.
- Top wall plus block: bally=0, dir_y=0, tb_pend=1 -> dir_y=1, bally=1.
- Paddle: bally=439, dir_y=1, ballx=paddle_x+63 -> dir_y=0, bally=438. Repeat with ballx=paddle_x+64 -> no bounce; ball continues to row 479, is lost on the next tick, ball_lost pulses 1 cycle, lives 3->2, state returns to IDLE.
- Game over: LIVES_INIT=1, lose ball -> game_over=1, start ignored for 20 cycles, rst -> lives=1, game_over=0.
